// File: rtl/ace_pcgen_if.sv
// ace_pcgen_if: groups the fetch-control bus of the ace21064 PC generator.
//   master : the PC generator itself (drives PCs, fetch request, status, counters)
//   slave  : the fetch/retire environment (drives flush, override, predictions, stalls, halt)
interface ace_pcgen_if;
  logic        flush_rt_i;
  logic [63:0] flush_pc_rt_i;
  logic        override_vld_f1_i;
  logic [63:0] override_pc_f1_i;
  logic [63:0] nxt_pc_f0_i;
  logic        icache_stall_i;
  logic        instbuf_full_i;
  logic        bob_stall_i;
  logic        halt_i;
  logic [63:0] pc_f0_o;
  logic [63:0] pc_f1_o;
  logic        pc_f1_vld_o;
  logic        fetch_req_o;
  logic        halted_o;
  logic [15:0] stall_cnt_o;
  logic [15:0] redirect_cnt_o;

  modport master (
    input  flush_rt_i, flush_pc_rt_i, override_vld_f1_i, override_pc_f1_i,
           nxt_pc_f0_i, icache_stall_i, instbuf_full_i, bob_stall_i, halt_i,
    output pc_f0_o, pc_f1_o, pc_f1_vld_o, fetch_req_o, halted_o,
           stall_cnt_o, redirect_cnt_o
  );

  modport slave (
    output flush_rt_i, flush_pc_rt_i, override_vld_f1_i, override_pc_f1_i,
           nxt_pc_f0_i, icache_stall_i, instbuf_full_i, bob_stall_i, halt_i,
    input  pc_f0_o, pc_f1_o, pc_f1_vld_o, fetch_req_o, halted_o,
           stall_cnt_o, redirect_cnt_o
  );
endinterface

// File: rtl/ace_pcgen.sv
// ace_pcgen: next-fetch-PC controller for the two-stage fetch pipeline.
// Selects pc_f0 from retire flush > f1 override > hold on stall > f0 prediction,
// sequences BOOT -> RUN <-> HALT, and keeps saturating stall/redirect counters.
// Ports:
//   clock  : rising-edge clock
//   reset  : asynchronous active-high reset
//   bus    : ace_pcgen_if.master (flush/override/prediction/stall/halt in;
//            pc_f0/pc_f1/valid/fetch_req/halted/counters out)
module ace_pcgen #(
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter int unsigned BOOT_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  ace_pcgen_if.master bus
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  boot_cnt;
  logic [63:0] pc_f0, pc_f1;
  logic        pc_f1_vld;
  logic        fetch_req;
  logic [15:0] stall_cnt, redirect_cnt;

  logic        stall, redir, in_run, redir_acc;

  always_comb begin
    stall     = bus.icache_stall_i | bus.instbuf_full_i | bus.bob_stall_i;
    redir     = bus.flush_rt_i | bus.override_vld_f1_i;
    in_run    = (state == S_RUN);
    // Overrides only steer in RUN; a flush is honoured in every state.
    redir_acc = bus.flush_rt_i | (in_run & bus.override_vld_f1_i);
    state_nxt = state;
    unique case (state)
      S_BOOT:  if (boot_cnt == '0) state_nxt = S_RUN;
      S_RUN:   if (bus.halt_i & ~bus.flush_rt_i) state_nxt = S_HALT;
      S_HALT:  if (~bus.halt_i) state_nxt = S_RUN;
      default: state_nxt = S_BOOT;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= S_BOOT;
      boot_cnt     <= 4'(BOOT_CYCLES - 1);
      pc_f0        <= RESET_PC;
      pc_f1        <= '0;
      pc_f1_vld    <= 1'b0;
      fetch_req    <= 1'b0;
      stall_cnt    <= '0;
      redirect_cnt <= '0;
    end else begin
      state <= state_nxt;

      if (state == S_BOOT && boot_cnt != '0)
        boot_cnt <= boot_cnt - 4'd1;

      if (bus.flush_rt_i)
        pc_f0 <= {bus.flush_pc_rt_i[63:2], 2'b00};
      else if (in_run & bus.override_vld_f1_i)
        pc_f0 <= {bus.override_pc_f1_i[63:2], 2'b00};
      else if (in_run & ~stall)
        pc_f0 <= {bus.nxt_pc_f0_i[63:2], 2'b00};

      // pc_f1 only ever captures pc_f0 on a clean advance; redirects kill the
      // f1 slot but leave its PC in place.
      if (in_run) begin
        if (redir)
          pc_f1_vld <= 1'b0;
        else if (~stall) begin
          pc_f1     <= pc_f0;
          pc_f1_vld <= 1'b1;
        end
      end else begin
        pc_f1_vld <= 1'b0;
      end

      fetch_req <= (state_nxt == S_RUN) & ~stall;

      if (in_run & stall & ~redir & (stall_cnt != '1))
        stall_cnt <= stall_cnt + 16'd1;

      if (redir_acc & (redirect_cnt != '1))
        redirect_cnt <= redirect_cnt + 16'd1;
    end
  end

  assign bus.pc_f0_o        = pc_f0;
  assign bus.pc_f1_o        = pc_f1;
  assign bus.pc_f1_vld_o    = pc_f1_vld;
  assign bus.fetch_req_o    = fetch_req;
  assign bus.halted_o       = (state == S_HALT);
  assign bus.stall_cnt_o    = stall_cnt;
  assign bus.redirect_cnt_o = redirect_cnt;

endmodule

// File: tb/tb_ace_pcgen.sv
module tb_ace_pcgen;
  localparam logic [63:0] RPC = 64'h1000;
  localparam int BOOTN = 4;
  localparam int M_BOOT = 0, M_RUN = 1, M_HALT = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  ace_pcgen_if bus ();

  ace_pcgen #(.RESET_PC(RPC), .BOOT_CYCLES(BOOTN)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode plus count of edges spent booting.
  int          m_mode, m_edges;
  logic [63:0] m_pc0, m_pc1;
  bit          m_vld, m_req;
  int          m_sc, m_rc;

  always @(posedge clock or posedge reset) begin : model
    int          n_mode, n_edges, n_sc, n_rc;
    logic [63:0] n_pc0, n_pc1;
    bit          n_vld, st, fl, ov;
    if (reset) begin
      m_mode <= M_BOOT; m_edges <= 0; m_pc0 <= RPC; m_pc1 <= '0;
      m_vld <= 0; m_req <= 0; m_sc <= 0; m_rc <= 0;
    end else begin
      st = bus.icache_stall_i | bus.instbuf_full_i | bus.bob_stall_i;
      fl = bus.flush_rt_i;
      ov = bus.override_vld_f1_i;
      n_mode = m_mode; n_edges = m_edges; n_pc0 = m_pc0; n_pc1 = m_pc1;
      n_vld = m_vld; n_sc = m_sc; n_rc = m_rc;
      if (m_mode == M_RUN && st && !(fl || ov)) n_sc = (m_sc < 65535) ? m_sc + 1 : 65535;
      if (fl || (m_mode == M_RUN && ov))        n_rc = (m_rc < 65535) ? m_rc + 1 : 65535;
      if (fl)                          n_pc0 = bus.flush_pc_rt_i & ~64'h3;
      else if (m_mode == M_RUN && ov)  n_pc0 = bus.override_pc_f1_i & ~64'h3;
      else if (m_mode == M_RUN && !st) n_pc0 = bus.nxt_pc_f0_i & ~64'h3;
      if (m_mode != M_RUN)   n_vld = 0;
      else if (fl || ov)     n_vld = 0;
      else if (!st) begin n_pc1 = m_pc0; n_vld = 1; end
      case (m_mode)
        M_BOOT: begin n_edges = m_edges + 1; if (n_edges == BOOTN) n_mode = M_RUN; end
        M_RUN:  if (bus.halt_i && !fl) n_mode = M_HALT;
        default: if (!bus.halt_i) n_mode = M_RUN;
      endcase
      m_mode <= n_mode; m_edges <= n_edges; m_pc0 <= n_pc0; m_pc1 <= n_pc1;
      m_vld <= n_vld; m_req <= (n_mode == M_RUN) && !st; m_sc <= n_sc; m_rc <= n_rc;
    end
  end

  always @(negedge clock) begin
    if (chk_on) begin
      chk("pc_f0",     bus.pc_f0_o, m_pc0);
      chk("pc_f1",     bus.pc_f1_o, m_pc1);
      chk("pc_f1_vld", 64'(bus.pc_f1_vld_o), 64'(m_vld));
      chk("fetch_req", 64'(bus.fetch_req_o), 64'(m_req));
      chk("halted",    64'(bus.halted_o), 64'(m_mode == M_HALT));
      chk("stall_cnt", 64'(bus.stall_cnt_o), 64'(m_sc));
      chk("redir_cnt", 64'(bus.redirect_cnt_o), 64'(m_rc));
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    bus.flush_rt_i = 0; bus.flush_pc_rt_i = '0;
    bus.override_vld_f1_i = 0; bus.override_pc_f1_i = '0;
    bus.nxt_pc_f0_i = '0; bus.icache_stall_i = 0; bus.instbuf_full_i = 0;
    bus.bob_stall_i = 0; bus.halt_i = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pc_f0"},  bus.pc_f0_o, 64'h1000);
    chk({tag, "_pc_f1"},  bus.pc_f1_o, 64'h0);
    chk({tag, "_vld"},    64'(bus.pc_f1_vld_o), 64'h0);
    chk({tag, "_req"},    64'(bus.fetch_req_o), 64'h0);
    chk({tag, "_halted"}, 64'(bus.halted_o), 64'h0);
    chk({tag, "_sc"},     64'(bus.stall_cnt_o), 64'h0);
    chk({tag, "_rc"},     64'(bus.redirect_cnt_o), 64'h0);
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    step(); step();
    chk_on = 1'b1;
    chk_reset_vals("reset");
    reset = 1'b0;

    // Boot: no fetch request for BOOT_CYCLES edges.
    bus.nxt_pc_f0_i = 64'h1020;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("boot_req_low", 64'(bus.fetch_req_o), 64'h0);
    end
    step();
    chk("boot_req_high", 64'(bus.fetch_req_o), 64'h1);
    chk("boot_pc_f0", bus.pc_f0_o, 64'h1000);

    // Sequential run.
    bus.nxt_pc_f0_i = m_pc0 + 64'd32;
    step();
    chk("seq_pc_f0_a", bus.pc_f0_o, 64'h1020);
    chk("seq_pc_f1_a", bus.pc_f1_o, 64'h1000);
    chk("seq_vld_a",   64'(bus.pc_f1_vld_o), 64'h1);
    bus.nxt_pc_f0_i = m_pc0 + 64'd32;
    step();
    chk("seq_pc_f0_b", bus.pc_f0_o, 64'h1040);
    chk("seq_pc_f1_b", bus.pc_f1_o, 64'h1020);

    // Stall: instbuf full 3 cycles, then icache stall 2 more.
    bus.nxt_pc_f0_i = 64'h1060;
    bus.instbuf_full_i = 1;
    step(); step(); step();
    chk("stall_pc_f0", bus.pc_f0_o, 64'h1040);
    chk("stall_pc_f1", bus.pc_f1_o, 64'h1020);
    chk("stall_cnt3",  64'(bus.stall_cnt_o), 64'd3);
    bus.instbuf_full_i = 0; bus.icache_stall_i = 1;
    step(); step();
    chk("stall_cnt5",  64'(bus.stall_cnt_o), 64'd5);

    // Flush + override collision while stalled.
    bus.flush_rt_i = 1; bus.flush_pc_rt_i = 64'h2000;
    bus.override_vld_f1_i = 1; bus.override_pc_f1_i = 64'h3000;
    step();
    chk("coll_pc_f0", bus.pc_f0_o, 64'h2000);
    chk("coll_vld",   64'(bus.pc_f1_vld_o), 64'h0);
    chk("coll_rc",    64'(bus.redirect_cnt_o), 64'd1);
    chk("coll_sc",    64'(bus.stall_cnt_o), 64'd5);

    // Halt, flush while halted, release.
    clear_inputs();
    bus.halt_i = 1; bus.nxt_pc_f0_i = 64'h2020;
    step();
    chk("halt_halted", 64'(bus.halted_o), 64'h1);
    chk("halt_req",    64'(bus.fetch_req_o), 64'h0);
    bus.flush_rt_i = 1; bus.flush_pc_rt_i = 64'h4003;
    step();
    chk("halt_flush_pc", bus.pc_f0_o, 64'h4000);
    chk("halt_flush_rc", 64'(bus.redirect_cnt_o), 64'd2);
    chk("halt_stays",    64'(bus.halted_o), 64'h1);
    bus.flush_rt_i = 0; bus.halt_i = 0;
    step();
    chk("rel_req",    64'(bus.fetch_req_o), 64'h1);
    chk("rel_halted", 64'(bus.halted_o), 64'h0);
    chk("rel_pc_f0",  bus.pc_f0_o, 64'h4000);
    bus.nxt_pc_f0_i = 64'h4020;
    step();
    chk("rel_pc_f1", bus.pc_f1_o, 64'h4000);
    chk("rel_vld",   64'(bus.pc_f1_vld_o), 64'h1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bus.flush_rt_i        = ($urandom_range(0, 15) == 0);
      bus.flush_pc_rt_i     = {$urandom, $urandom};
      bus.override_vld_f1_i = ($urandom_range(0, 7) == 0);
      bus.override_pc_f1_i  = {$urandom, $urandom};
      bus.nxt_pc_f0_i       = {$urandom, $urandom};
      bus.icache_stall_i    = ($urandom_range(0, 5) == 0);
      bus.instbuf_full_i    = ($urandom_range(0, 5) == 0);
      bus.bob_stall_i       = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 31) == 0) bus.halt_i = ~bus.halt_i;
      step();
    end

    // Saturate the stall counter.
    clear_inputs();
    bus.instbuf_full_i = 1;
    for (int i = 0; i < 70000; i++) step();
    chk("sat_stall", 64'(bus.stall_cnt_o), 64'hFFFF);

    // Asynchronous reset in the middle of a redirect.
    bus.instbuf_full_i = 0;
    bus.flush_rt_i = 1; bus.flush_pc_rt_i = 64'h5000;
    bus.override_vld_f1_i = 1; bus.override_pc_f1_i = 64'h6000;
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals("async");
    step();
    chk_reset_vals("held");
    clear_inputs();
    reset = 1'b0;
    step();
    chk("post_rst_pc_f0", bus.pc_f0_o, 64'h1000);
    chk("post_rst_req",   64'(bus.fetch_req_o), 64'h0);

    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
